fbs_ctrl: RTL and testbench

//  Initiator side of the f-register backup interface. Owns the 16x16 f-register file and turns processor call/ret

---
 rtl/fbs_pkg.sv | 20 ++
 rtl/fbs_if.sv | 16 +
 rtl/fbs_ctrl_f_regfile.sv | 38 +++
 rtl/fbs_ctrl.sv | 91 +++++++++
 tb/tb_fbs_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fbs_pkg.sv
// fbs_pkg: shared state encoding, error bit positions and default sizes for the f-register backup controller
package fbs_pkg;

    localparam int DEF_NREG    = 16;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 15;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_TO  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BACKUP  = 2'd1,
        ST_RESTORE = 2'd2,
        ST_LOAD    = 2'd3
    } state_t;

endpackage

// File: rtl/fbs_if.sv
// fbs_if: snapshot bus between the controller (master) and the fbs backup store (slave)
interface fbs_if #(
    parameter int NREG  = fbs_pkg::DEF_NREG,
    parameter int WIDTH = fbs_pkg::DEF_WIDTH
);

    logic                  backup;
    logic                  restore;
    logic [NREG*WIDTH-1:0] snapOut;
    logic [NREG*WIDTH-1:0] snapIn;
    logic                  restoreIn;

    modport master (output backup, restore, snapOut, input snapIn, restoreIn);
    modport slave  (input backup, restore, snapOut, output snapIn, restoreIn);

endinterface

// File: rtl/fbs_ctrl_f_regfile.sv
// f_regfile: NREG x WIDTH register file with one write port, two combinational reads and a whole-file bulk load
module f_regfile import fbs_pkg::*; #(
    parameter int NREG  = DEF_NREG,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0]  raddr0,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [WIDTH-1:0]         rdata0,
    output logic [WIDTH-1:0]         rdata1,
    input  logic                     load,
    input  logic [NREG*WIDTH-1:0]    loadData,
    output logic [NREG*WIDTH-1:0]    snap
);

    localparam int AW = $clog2(NREG);

    logic [WIDTH-1:0] f [NREG];

    // bulk load wins over the single write port
    always_ff @(posedge clk)
        for (int i = 0; i < NREG; i++)
            if (reset) f[i] <= '0;
            else if (load) f[i] <= loadData[WIDTH*i +: WIDTH];
            else if (we && waddr == AW'(i)) f[i] <= wdata;

    for (genvar i = 0; i < NREG; i++) begin : g_snap
        assign snap[WIDTH*i +: WIDTH] = f[i];
    end

    assign rdata0 = f[raddr0];
    assign rdata1 = f[raddr1];

endmodule

// File: rtl/fbs_ctrl.sv
// fbs_ctrl: turns call/ret into backup/restore pulses for fbs, tracks depth, timeouts and sticky errors, stalls the pipe
module fbs_ctrl import fbs_pkg::*; #(
    parameter int NREG    = DEF_NREG,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        call,
    input  logic                        ret,
    input  logic                        we,
    input  logic [$clog2(NREG)-1:0]     waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [$clog2(NREG)-1:0]     raddr0,
    input  logic [$clog2(NREG)-1:0]     raddr1,
    output logic [WIDTH-1:0]            rdata0,
    output logic [WIDTH-1:0]            rdata1,
    output logic                        stall,
    output logic [$clog2(DEPTH+1)-1:0]  depth,
    output logic [2:0]                  err,
    fbs_if.master                       bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DEPTH + 1);

    state_t                state, nstate;
    logic [CW-1:0]         cnt;
    logic                  idle, req_call, req_ret, full, empty;
    logic                  acc_call, acc_ret, load, tmo, wr;
    logic [NREG*WIDTH-1:0] snap;

    // a write in the cycle a call is accepted still lands, so the snapshot carries it
    always_comb begin
        idle     = state == ST_IDLE;
        req_call = idle & call & ~ret;
        req_ret  = idle & ret & ~call;
        full     = depth == DW'(DEPTH);
        empty    = depth == '0;
        acc_call = req_call & ~full;
        acc_ret  = req_ret & ~empty;
        load     = (state == ST_RESTORE) & bus.restoreIn;
        tmo      = (state == ST_RESTORE) & ~bus.restoreIn & (cnt == CW'(TIMEOUT));
        stall    = ~idle | acc_call | acc_ret;
        wr       = we & (~stall | acc_call);
        nstate   = state;
        case (state)
            ST_IDLE:    nstate = acc_call ? ST_BACKUP : acc_ret ? ST_RESTORE : ST_IDLE;
            ST_RESTORE: nstate = load ? ST_LOAD : tmo ? ST_IDLE : ST_RESTORE;
            default:    nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            depth <= '0;
            err   <= '0;
            cnt   <= CW'(1);
        end else begin
            state <= nstate;
            cnt   <= (state == ST_RESTORE) ? cnt + 1'b1 : CW'(1);
            if (acc_call) depth <= depth + 1'b1;
            else if (load | tmo) depth <= depth - 1'b1;
            if (req_call & full) err[ERR_OVF] <= 1'b1;
            if (req_ret & empty) err[ERR_UNF] <= 1'b1;
            if (tmo) err[ERR_TO] <= 1'b1;
        end
    end

    assign bus.backup  = state == ST_BACKUP;
    assign bus.restore = state == ST_RESTORE;
    assign bus.snapOut = snap;

    f_regfile #(.NREG(NREG), .WIDTH(WIDTH)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (wr),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr0   (raddr0),
        .raddr1   (raddr1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .load     (load),
        .loadData (bus.snapIn),
        .snap     (snap)
    );

endmodule

// File: tb/tb_fbs_ctrl.sv
// tb_fbs_ctrl: fbs_ctrl against a behavioural fbs store and a transaction-level model of the register file
module tb_fbs_ctrl;
    import fbs_pkg::*;

    localparam int NREG = 16, WIDTH = 16, DEPTH = 16, TIMEOUT = 15;
    typedef logic [NREG*WIDTH-1:0] snap_t;

    logic        clk = 1'b0, reset = 1'b1, call = 1'b0, ret = 1'b0, we = 1'b0;
    logic [3:0]  waddr = '0, raddr0 = '0, raddr1 = 4'd3;
    logic [15:0] wdata = '0;
    logic [15:0] rdata0, rdata1;
    logic        stall;
    logic [4:0]  depth;
    logic [2:0]  err;

    fbs_if #(.NREG(NREG), .WIDTH(WIDTH)) bus();

    fbs_ctrl #(.NREG(NREG), .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
        .stall(stall), .depth(depth), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [15:0] mf [NREG];
    int          mdepth = 0;
    logic [2:0]  merr = '0;
    snap_t       mstk[$];
    logic        exp_stall = 0, exp_backup = 0, exp_restore = 0;
    bit          chk_en = 0;
    int          bcount = 0, rhigh = 0;

    snap_t fbs_q[$];
    int    rc = 0, lat = 3;
    bit    stub = 0;

    function automatic snap_t pack();
        snap_t s;
        for (int i = 0; i < NREG; i++) s[WIDTH*i +: WIDTH] = mf[i];
        return s;
    endfunction

    task automatic unpack(input snap_t s);
        for (int i = 0; i < NREG; i++) mf[i] = s[WIDTH*i +: WIDTH];
    endtask

    task automatic chk(input string name, input snap_t act, input snap_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural fbs: LIFO of snapshots, answers a restore after lat cycles unless stubbed
    always @(negedge clk) begin
        if (bus.backup) fbs_q.push_back(bus.snapOut);
        if (bus.restore) begin
            rc++;
            if (!stub && rc == lat && fbs_q.size() > 0) begin
                bus.snapIn    = fbs_q.pop_back();
                bus.restoreIn = 1'b1;
            end else bus.restoreIn = 1'b0;
        end else begin
            rc            = 0;
            bus.restoreIn = 1'b0;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("stall", stall, exp_stall);
        chk("backup", bus.backup, exp_backup);
        chk("restore", bus.restore, exp_restore);
        chk("depth", depth, mdepth);
        chk("err", err, merr);
        chk("rdata0", rdata0, mf[raddr0]);
        chk("rdata1", rdata1, mf[raddr1]);
        chk("snapOut", bus.snapOut, pack());
        if (bus.backup) bcount++;
        if (bus.restore) rhigh++;
    end

    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        chk_en = 0;
        reset = 1'b1; call = 1'b0; ret = 1'b0; we = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        foreach (mf[i]) mf[i] = '0;
        mdepth = 0; merr = '0;
        mstk.delete(); fbs_q.delete();
        exp_stall = 0; exp_backup = 0; exp_restore = 0;
        chk_en = 1;
    endtask

    // one idle-state request and the whole transaction it triggers
    task automatic req(input bit c, input bit r, input bit w, input logic [3:0] a, input logic [15:0] d);
        bit ac, ar, got;
        int n;
        ac = c && !r && mdepth < DEPTH;
        ar = r && !c && mdepth > 0;
        call = c; ret = r; we = w; waddr = a; wdata = d; raddr0 = raddr0 + 1'b1;
        exp_stall = ac || ar; exp_backup = 0; exp_restore = 0;
        cyc();
        if (w && (ac || !ar)) mf[a] = d;
        if (c && !r && !ac) merr[ERR_OVF] = 1'b1;
        if (r && !c && !ar) merr[ERR_UNF] = 1'b1;
        call = 1'b0; ret = 1'b0; we = 1'b0;
        if (ac) begin
            mdepth++;
            mstk.push_back(pack());
            exp_backup = 1;
            cyc();
            exp_stall = 0; exp_backup = 0;
        end
        if (ar) begin
            got = !stub && lat <= TIMEOUT;
            n = got ? lat : TIMEOUT;
            exp_restore = 1;
            repeat (n) cyc();
            exp_restore = 0;
            mdepth--;
            if (got) begin
                unpack(mstk.pop_back());
                cyc();
            end else begin
                merr[ERR_TO] = 1'b1;
                void'(mstk.pop_back());
                if (fbs_q.size() > 0) void'(fbs_q.pop_back());
            end
            exp_stall = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        int b0, r0;
        snap_t first;
        bus.restoreIn = 1'b0;
        bus.snapIn    = '0;
        do_reset(2);
        chk("lit_reset_depth", depth, 5'd0);
        chk("lit_reset_err", err, 3'd0);
        chk("lit_reset_stall", stall, 1'b0);

        bcount = 0;
        req(1, 0, 1, 4'd3, 16'h00AB);
        chk("lit_call_depth", depth, 5'd1);
        chk("lit_call_pulses", bcount, 1);
        first = fbs_q[0];
        chk("lit_snap_f3", first[63:48], 16'h00AB);

        req(0, 0, 1, 4'd3, 16'h1234);
        chk("lit_write_f3", rdata1, 16'h1234);
        req(0, 1, 0, 4'd0, 16'h0);
        chk("lit_ret_f3", rdata1, 16'h00AB);
        chk("lit_ret_depth", depth, 5'd0);
        chk("lit_ret_err", err, 3'd0);

        for (int k = 0; k < 16; k++) req(1, 0, 1, 4'd0, 16'(k));
        b0 = bcount;
        req(1, 0, 1, 4'd0, 16'h0063);
        chk("lit_ovf_err", err, 3'b001);
        chk("lit_ovf_depth", depth, 5'd16);
        chk("lit_ovf_nopulse", bcount, b0);
        raddr1 = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            req(0, 1, 0, 4'd0, 16'h0);
            chk("lit_lifo_f0", rdata1, 16'(k));
        end

        r0 = rhigh;
        req(0, 1, 0, 4'd0, 16'h0);
        chk("lit_unf_err", err, 3'b011);
        chk("lit_unf_norestore", rhigh, r0);
        raddr1 = 4'd2;
        req(1, 1, 1, 4'd2, 16'hBEEF);
        chk("lit_both_depth", depth, 5'd0);
        chk("lit_both_err", err, 3'b011);
        chk("lit_both_write", rdata1, 16'hBEEF);

        raddr1 = 4'd5;
        req(1, 0, 1, 4'd5, 16'h0077);
        req(0, 0, 1, 4'd5, 16'h0099);
        stub = 1; rhigh = 0;
        req(0, 1, 0, 4'd0, 16'h0);
        stub = 0;
        chk("lit_to_cycles", rhigh, 15);
        chk("lit_to_err", err, 3'b111);
        chk("lit_to_depth", depth, 5'd0);
        chk("lit_to_file", rdata1, 16'h0099);

        req(1, 0, 1, 4'd5, 16'h0042);
        stub = 1;
        ret = 1'b1; exp_stall = 1;
        cyc();
        ret = 1'b0; exp_restore = 1;
        repeat (3) cyc();
        do_reset(1);
        stub = 0;
        chk("lit_rst_restore", bus.restore, 1'b0);
        chk("lit_rst_stall", stall, 1'b0);
        chk("lit_rst_depth", depth, 5'd0);
        chk("lit_rst_err", err, 3'd0);
        chk("lit_rst_f5", rdata1, 16'h0);
        chk("lit_rst_snap", bus.snapOut, '0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
